uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
Parametrised UART receiver, the successor to the fixed 8-bit receiver.
- Oversamples RX_IN by a runtime prescale and majority-votes three samples per bit.
- Supports configurable data width, optional even/odd parity and one or two stop bits.
- Presents the received word with a one-cycle valid strobe and separate parity/stop error strobes.
- Sits between the pad synchroniser and the receive FIFO/register interface.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (legal 5..9), LSB first.
PRESC_WIDTH, 6, width of the prescale port; oversampling ratio up to 2^PRESC_WIDTH-1.

Ports:
CLK  input  1  receiver clock (oversampling clock).
RST  input  1  asynchronous active-low reset.
RX_IN  input  1  serial line, idle high, already synchronised.
PAR_EN  input  1  1 = frame carries a parity bit.
PAR_TYP  input  1  0 = even parity, 1 = odd parity.
STOP2  input  1  1 = two stop bits, 0 = one.
prescale  input  PRESC_WIDTH  clocks per bit; values below 4 are treated as 4.
P_DATA  output  DATA_WIDTH  last good received word.
DATA_VALID  output  1  one-cycle pulse: P_DATA updated with an error-free frame.
PAR_ERR  output  1  one-cycle pulse: parity mismatch.
STP_ERR  output  1  one-cycle pulse: a stop bit sampled low.

Behaviour:
- Reset (RST=0, async): state IDLE; counters cleared; P_DATA=0, DATA_VALID=0, PAR_ERR=0, STP_ERR=0. Reset mid-frame discards the frame; no strobes are produced.
- Configuration capture: PAR_EN, PAR_TYP, STOP2 and prescale (after the clamp) are latched on the start-detect cycle. Changes during a frame are ignored until the next frame.
- Counters:
  - edge_cnt runs 0..P-1 within each bit (P = latched prescale).
  - bit_cnt counts the bits of the current state.
- Sampling: c = P>>1. RX_IN is sampled at edge_cnt = c-1, c, c+1. The bit value is the majority of the three samples and is resolved at edge_cnt = c+1.
- State IDLE: when RX_IN=0, this is the start-detect cycle (cycle 0). edge_cnt=0 and the FSM goes to START.
- State START: if the voted value is 1, the low was a glitch. Return to IDLE at the end of the bit with no strobes. If it is 0, go to DATA at the end of the bit.
- State DATA: shift in DATA_WIDTH bits, LSB first. After the last bit, go to PARITY if PAR_EN, else STOP.
- State PARITY: expected bit = XOR(data) ^ PAR_TYP. A mismatch sets an internal parity-fail flag.
- State STOP: one or two bits per STOP2. Any voted 0 sets an internal stop-fail flag.
- End of frame, at the last edge_cnt of the final stop bit:
  - Error-free frame: P_DATA is loaded and DATA_VALID pulses.
  - Any error: PAR_ERR and/or STP_ERR pulse (both may pulse together); DATA_VALID stays 0 and P_DATA holds its old value.
  - The FSM returns to IDLE in the same cycle.
- Latency: strobes are high in cycle N*P after the start-detect cycle, for exactly one cycle. N = 1 + DATA_WIDTH + PAR_EN + (STOP2 ? 2 : 1).
- Back-to-back frames: a start bit that begins on the cycle after the strobe is detected with no lost bit.
- Line held low through the stop bit (break): STP_ERR pulses, then IDLE waits for RX_IN=0. A continuous break therefore re-enters START immediately.

Test Plan:
- DATA_WIDTH=8, P=8, PAR_EN=1, PAR_TYP=0, one stop, send 0xA5 with parity 0 -> DATA_VALID pulse at cycle 88, P_DATA=0xA5, PAR_ERR=STP_ERR=0.
- Same frame with PAR_TYP=1 and parity bit 0 -> PAR_ERR pulse at cycle 88, DATA_VALID=0, P_DATA keeps 0xA5.
- P=16, STOP2=1, PAR_EN=0, send 0x3C then 0xC3 back to back with the second stop bit low on the second frame -> DATA_VALID at cycle 176 with 0x3C; STP_ERR at cycle 352 of the stream; P_DATA=0x3C.
- RX_IN low for 2 cycles then high, P=8 -> no strobe; a valid 0x5A frame started 10 cycles later is received correctly.
- Single-cycle low glitch at the sample point c of bit 3 while sending 0xFF, P=8 -> majority vote recovers it; P_DATA=0xFF, DATA_VALID pulses.
- Assert RST low during DATA bit 4, release, then send 0x81 -> no strobes during or after reset until the 0x81 frame, which yields DATA_VALID with P_DATA=0x81.

Source files
------------

// File: rtl/uart_rx_param.sv
// uart_rx_param
//   Parametrised UART receiver. The receiver oversamples RX_IN by a runtime
//   prescale and majority-votes three samples around each bit centre. It
//   supports DATA_WIDTH data bits (LSB first), optional even/odd parity and
//   one or two stop bits. A good word is presented with a one-cycle valid
//   strobe. Faulty frames produce one-cycle parity/stop error strobes.
//
// Ports
//   CLK        oversampling clock
//   RST        asynchronous active-low reset
//   RX_IN      synchronised serial line, idle high
//   PAR_EN     frame carries a parity bit
//   PAR_TYP    0 = even parity, 1 = odd parity
//   STOP2      1 = two stop bits, 0 = one
//   prescale   clocks per bit (values below 4 act as 4)
//   P_DATA     last error-free received word
//   DATA_VALID one-cycle pulse, P_DATA updated
//   PAR_ERR    one-cycle pulse, parity mismatch
//   STP_ERR    one-cycle pulse, a stop bit voted low
module uart_rx_param #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned PRESC_WIDTH = 6
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   RX_IN,
    input  logic                   PAR_EN,
    input  logic                   PAR_TYP,
    input  logic                   STOP2,
    input  logic [PRESC_WIDTH-1:0] prescale,
    output logic [DATA_WIDTH-1:0]  P_DATA,
    output logic                   DATA_VALID,
    output logic                   PAR_ERR,
    output logic                   STP_ERR
);

    localparam logic [PRESC_WIDTH-1:0] PRESC_MIN = PRESC_WIDTH'(4);
    localparam logic [3:0]             LAST_DATA = 4'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t state, state_n;

    logic [PRESC_WIDTH-1:0] presc_q;
    logic [PRESC_WIDTH-1:0] presc_eff;
    logic [PRESC_WIDTH-1:0] edge_cnt;
    logic [PRESC_WIDTH-1:0] center;
    logic [PRESC_WIDTH-1:0] samp_lo;
    logic [PRESC_WIDTH-1:0] samp_hi;
    logic [PRESC_WIDTH-1:0] last_edge;
    logic [3:0]             bit_cnt;
    logic [3:0]             last_stop;
    logic                   par_en_q, par_typ_q, stop2_q;
    logic                   s0, s1;
    logic [DATA_WIDTH-1:0]  shreg;
    logic                   start_bad, par_fail, stp_fail;
    logic                   bit_end, vote_pt, vote;
    logic                   start_bad_now, stp_fail_now;
    logic                   frame_end;

    assign presc_eff = (prescale < PRESC_MIN) ? PRESC_MIN : prescale;
    assign center    = presc_q >> 1;
    assign samp_lo   = center - PRESC_WIDTH'(1);
    assign samp_hi   = center + PRESC_WIDTH'(1);
    assign last_edge = presc_q - PRESC_WIDTH'(1);
    assign last_stop = stop2_q ? 4'd1 : 4'd0;

    assign bit_end = (edge_cnt == last_edge);
    assign vote_pt = (edge_cnt == samp_hi);
    // Third sample is taken live at the resolve point.
    assign vote    = (s0 & s1) | (s0 & RX_IN) | (s1 & RX_IN);

    // With P = 4 the resolve point is also the last edge of the bit, so the
    // flags consulted at the bit end fold in the vote of this cycle.
    assign start_bad_now = start_bad | (vote_pt & vote);
    assign stp_fail_now  = stp_fail  | (vote_pt & ~vote);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n   = state;
        frame_end = 1'b0;
        case (state)
            IDLE:   if (!RX_IN) state_n = START;
            START:  if (bit_end) state_n = start_bad_now ? IDLE : DATA;
            DATA:   if (bit_end && bit_cnt == LAST_DATA)
                        state_n = par_en_q ? PARITY : STOP;
            PARITY: if (bit_end) state_n = STOP;
            STOP:   if (bit_end && bit_cnt == last_stop) begin
                        state_n   = IDLE;
                        frame_end = 1'b1;
                    end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            presc_q    <= PRESC_MIN;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            stop2_q    <= 1'b0;
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            s0         <= 1'b1;
            s1         <= 1'b1;
            shreg      <= '0;
            start_bad  <= 1'b0;
            par_fail   <= 1'b0;
            stp_fail   <= 1'b0;
            P_DATA     <= '0;
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
        end else begin
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
            if (state == IDLE) begin
                if (!RX_IN) begin
                    // Detect cycle counts as edge 0 of the start bit.
                    presc_q   <= presc_eff;
                    par_en_q  <= PAR_EN;
                    par_typ_q <= PAR_TYP;
                    stop2_q   <= STOP2;
                    edge_cnt  <= PRESC_WIDTH'(1);
                    bit_cnt   <= '0;
                    start_bad <= 1'b0;
                    par_fail  <= 1'b0;
                    stp_fail  <= 1'b0;
                end
            end else begin
                edge_cnt <= bit_end ? '0 : edge_cnt + PRESC_WIDTH'(1);
                if (bit_end)
                    bit_cnt <= (state_n != state) ? '0 : bit_cnt + 4'd1;
                if (edge_cnt == samp_lo) s0 <= RX_IN;
                if (edge_cnt == center)  s1 <= RX_IN;
                if (vote_pt) begin
                    case (state)
                        START:  start_bad <= start_bad_now;
                        DATA:   shreg <= {vote, shreg[DATA_WIDTH-1:1]};
                        PARITY: if (vote != ((^shreg) ^ par_typ_q)) par_fail <= 1'b1;
                        STOP:   stp_fail <= stp_fail_now;
                        default: ;
                    endcase
                end
                if (frame_end) begin
                    if (!par_fail && !stp_fail_now) begin
                        P_DATA     <= shreg;
                        DATA_VALID <= 1'b1;
                    end else begin
                        PAR_ERR <= par_fail;
                        STP_ERR <= stp_fail_now;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
module tb_uart_rx_param;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic       PAR_EN, PAR_TYP, STOP2;
    logic [5:0] prescale;
    logic [7:0] P_DATA;
    logic       DATA_VALID, PAR_ERR, STP_ERR;

    uart_rx_param #(.DATA_WIDTH(8), .PRESC_WIDTH(6)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
        .STOP2(STOP2), .prescale(prescale), .P_DATA(P_DATA),
        .DATA_VALID(DATA_VALID), .PAR_ERR(PAR_ERR), .STP_ERR(STP_ERR)
    );

    always #5 CLK = ~CLK;

    localparam int LEN = 512;

    logic       line_q [0:LEN-1];
    logic       rst_q  [0:LEN-1];
    logic       dv_r   [0:LEN-1];
    logic       pe_r   [0:LEN-1];
    logic       se_r   [0:LEN-1];
    logic [7:0] pd_r   [0:LEN-1];

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic clear_line();
        for (int i = 0; i < LEN; i++) begin
            line_q[i] = 1'b1;
            rst_q[i]  = 1'b1;
        end
    endtask

    task automatic put_bit(input int pos, input int p, input logic val);
        for (int i = 0; i < p; i++) line_q[pos + i] = val;
    endtask

    // Lays one 8-bit frame on the line starting at cycle 'start'.
    task automatic put_frame(input int start, input logic [7:0] data, input int p,
                             input logic par_en, input logic par_bit,
                             input logic stop_a, input logic stop_b, input logic stop2);
        int pos;
        pos = start;
        put_bit(pos, p, 1'b0); pos += p;
        for (int b = 0; b < 8; b++) begin
            put_bit(pos, p, data[b]); pos += p;
        end
        if (par_en) begin put_bit(pos, p, par_bit); pos += p; end
        put_bit(pos, p, stop_a); pos += p;
        if (stop2) put_bit(pos, p, stop_b);
    endtask

    // Entered just after a rising edge; drives cycle i, samples it at the
    // falling edge, and leaves just after the next rising edge.
    task automatic play(input int n);
        for (int i = 0; i < n; i++) begin
            RST   = rst_q[i];
            RX_IN = line_q[i];
            @(negedge CLK);
            dv_r[i] = DATA_VALID;
            pe_r[i] = PAR_ERR;
            se_r[i] = STP_ERR;
            pd_r[i] = P_DATA;
            @(posedge CLK);
            #1;
        end
    endtask

    function automatic int count_pulses(input int kind, input int n);
        int c;
        c = 0;
        for (int i = 0; i < n; i++) begin
            if (kind == 0 && dv_r[i] === 1'b1) c++;
            if (kind == 1 && pe_r[i] === 1'b1) c++;
            if (kind == 2 && se_r[i] === 1'b1) c++;
        end
        return c;
    endfunction

    task automatic test_reset();
        RST = 1'b0; RX_IN = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0; prescale = 6'd8;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        total_cnt++; if (P_DATA !== 8'h00) $display("FAIL reset_pdata: got %0h expected 00", P_DATA); else pass_cnt++;
        total_cnt++; if (DATA_VALID !== 1'b0) $display("FAIL reset_dv: got %b expected 0", DATA_VALID); else pass_cnt++;
        total_cnt++; if (PAR_ERR !== 1'b0) $display("FAIL reset_pe: got %b expected 0", PAR_ERR); else pass_cnt++;
        total_cnt++; if (STP_ERR !== 1'b0) $display("FAIL reset_se: got %b expected 0", STP_ERR); else pass_cnt++;
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_parity_good();
        int n;
        n = 100;
        PAR_EN = 1'b1; PAR_TYP = 1'b0; STOP2 = 1'b0; prescale = 6'd8;
        clear_line();
        put_frame(4, 8'hA5, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        play(n);
        total_cnt++; if (dv_r[92] !== 1'b1) $display("FAIL even_dv_at_88: got %b expected 1", dv_r[92]); else pass_cnt++;
        total_cnt++; if (pd_r[92] !== 8'hA5) $display("FAIL even_pdata: got %0h expected a5", pd_r[92]); else pass_cnt++;
        total_cnt++; if (count_pulses(0, n) !== 1) $display("FAIL even_dv_count: got %0d expected 1", count_pulses(0, n)); else pass_cnt++;
        total_cnt++; if (count_pulses(1, n) + count_pulses(2, n) !== 0) $display("FAIL even_err_count: got %0d expected 0", count_pulses(1, n) + count_pulses(2, n)); else pass_cnt++;
    endtask

    task automatic test_parity_err();
        int n;
        n = 100;
        PAR_EN = 1'b1; PAR_TYP = 1'b1; STOP2 = 1'b0; prescale = 6'd8;
        clear_line();
        put_frame(4, 8'hA5, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        play(n);
        total_cnt++; if (pe_r[92] !== 1'b1) $display("FAIL odd_pe_at_88: got %b expected 1", pe_r[92]); else pass_cnt++;
        total_cnt++; if (count_pulses(1, n) !== 1) $display("FAIL odd_pe_count: got %0d expected 1", count_pulses(1, n)); else pass_cnt++;
        total_cnt++; if (count_pulses(0, n) !== 0) $display("FAIL odd_dv_count: got %0d expected 0", count_pulses(0, n)); else pass_cnt++;
        total_cnt++; if (count_pulses(2, n) !== 0) $display("FAIL odd_se_count: got %0d expected 0", count_pulses(2, n)); else pass_cnt++;
        total_cnt++; if (pd_r[n-1] !== 8'hA5) $display("FAIL odd_pdata_hold: got %0h expected a5", pd_r[n-1]); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int n;
        n = 364;
        PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b1; prescale = 6'd16;
        clear_line();
        put_frame(4,   8'h3C, 16, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        put_frame(180, 8'hC3, 16, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        play(n);
        total_cnt++; if (dv_r[180] !== 1'b1) $display("FAIL b2b_dv_at_176: got %b expected 1", dv_r[180]); else pass_cnt++;
        total_cnt++; if (pd_r[180] !== 8'h3C) $display("FAIL b2b_pdata1: got %0h expected 3c", pd_r[180]); else pass_cnt++;
        total_cnt++; if (se_r[356] !== 1'b1) $display("FAIL b2b_se_at_352: got %b expected 1", se_r[356]); else pass_cnt++;
        total_cnt++; if (count_pulses(0, n) !== 1) $display("FAIL b2b_dv_count: got %0d expected 1", count_pulses(0, n)); else pass_cnt++;
        total_cnt++; if (count_pulses(2, n) !== 1) $display("FAIL b2b_se_count: got %0d expected 1", count_pulses(2, n)); else pass_cnt++;
        total_cnt++; if (count_pulses(1, n) !== 0) $display("FAIL b2b_pe_count: got %0d expected 0", count_pulses(1, n)); else pass_cnt++;
        total_cnt++; if (pd_r[n-1] !== 8'h3C) $display("FAIL b2b_pdata_hold: got %0h expected 3c", pd_r[n-1]); else pass_cnt++;
    endtask

    task automatic test_glitch_start();
        int n;
        n = 110;
        PAR_EN = 1'b1; PAR_TYP = 1'b0; STOP2 = 1'b0; prescale = 6'd8;
        clear_line();
        line_q[4] = 1'b0;
        line_q[5] = 1'b0;
        put_frame(14, 8'h5A, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        play(n);
        total_cnt++; if (dv_r[102] !== 1'b1) $display("FAIL glitch_dv_at: got %b expected 1", dv_r[102]); else pass_cnt++;
        total_cnt++; if (pd_r[102] !== 8'h5A) $display("FAIL glitch_pdata: got %0h expected 5a", pd_r[102]); else pass_cnt++;
        total_cnt++; if (count_pulses(0, n) !== 1) $display("FAIL glitch_dv_count: got %0d expected 1", count_pulses(0, n)); else pass_cnt++;
        total_cnt++; if (count_pulses(1, n) + count_pulses(2, n) !== 0) $display("FAIL glitch_err_count: got %0d expected 0", count_pulses(1, n) + count_pulses(2, n)); else pass_cnt++;
    endtask

    task automatic test_majority();
        int n;
        n = 100;
        PAR_EN = 1'b1; PAR_TYP = 1'b0; STOP2 = 1'b0; prescale = 6'd8;
        clear_line();
        put_frame(4, 8'hFF, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        line_q[4 + 4*8 + 4] = 1'b0;
        play(n);
        total_cnt++; if (dv_r[92] !== 1'b1) $display("FAIL vote_dv_at: got %b expected 1", dv_r[92]); else pass_cnt++;
        total_cnt++; if (pd_r[92] !== 8'hFF) $display("FAIL vote_pdata: got %0h expected ff", pd_r[92]); else pass_cnt++;
        total_cnt++; if (count_pulses(1, n) + count_pulses(2, n) !== 0) $display("FAIL vote_err_count: got %0d expected 0", count_pulses(1, n) + count_pulses(2, n)); else pass_cnt++;
    endtask

    task automatic test_reset_mid_frame();
        int n;
        n = 150;
        PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0; prescale = 6'd8;
        clear_line();
        put_frame(4, 8'h00, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 48; i < 60; i++) line_q[i] = 1'b1;
        rst_q[46] = 1'b0;
        rst_q[47] = 1'b0;
        put_frame(60, 8'h81, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        play(n);
        total_cnt++; if (pd_r[50] !== 8'h00) $display("FAIL rst_mid_pdata_clear: got %0h expected 00", pd_r[50]); else pass_cnt++;
        total_cnt++; if (dv_r[140] !== 1'b1) $display("FAIL rst_mid_dv_at: got %b expected 1", dv_r[140]); else pass_cnt++;
        total_cnt++; if (pd_r[140] !== 8'h81) $display("FAIL rst_mid_pdata: got %0h expected 81", pd_r[140]); else pass_cnt++;
        total_cnt++; if (count_pulses(0, n) !== 1) $display("FAIL rst_mid_dv_count: got %0d expected 1", count_pulses(0, n)); else pass_cnt++;
        total_cnt++; if (count_pulses(1, n) + count_pulses(2, n) !== 0) $display("FAIL rst_mid_err_count: got %0d expected 0", count_pulses(1, n) + count_pulses(2, n)); else pass_cnt++;
    endtask

    task automatic test_prescale_clamp();
        int n;
        n = 52;
        PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0; prescale = 6'd2;
        clear_line();
        put_frame(4, 8'h96, 4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        play(n);
        total_cnt++; if (dv_r[44] !== 1'b1) $display("FAIL clamp_dv_at_40: got %b expected 1", dv_r[44]); else pass_cnt++;
        total_cnt++; if (pd_r[44] !== 8'h96) $display("FAIL clamp_pdata: got %0h expected 96", pd_r[44]); else pass_cnt++;
        total_cnt++; if (count_pulses(0, n) !== 1) $display("FAIL clamp_dv_count: got %0d expected 1", count_pulses(0, n)); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_parity_good();
        test_parity_err();
        test_back_to_back();
        test_glitch_start();
        test_majority();
        test_reset_mid_frame();
        test_prescale_clamp();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
